// File: rtl/da_pkg.sv
// da_pkg: shared FSM state type and width helpers for the distributed-arithmetic inner-product engine.
package da_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int lut_w(input int cw, input int k);
        return cw + $clog2(k);
    endfunction

    function automatic int res_w(input int w, input int cw, input int k);
        return w + cw + $clog2(k);
    endfunction

endpackage

// File: rtl/da_lut.sv
// da_lut: combinational sum of the coefficients selected by a K-bit mask.
// DA_SIGNED_EN: coefficients are sign-extended before summing.
module da_lut
    import da_pkg::*;
#(
    parameter int K  = 4,
    parameter int CW = 8
) (
    input  logic [K*CW-1:0]          coef,
    input  logic [K-1:0]             mask,
    output logic [lut_w(CW, K)-1:0]  lut
);

    localparam int LW = lut_w(CW, K);
`ifdef DA_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    always_comb begin
        lut = '0;
        for (int k = 0; k < K; k++)
            if (mask[k])
                lut = lut + {{(LW-CW){SGN & coef[k*CW+CW-1]}}, coef[k*CW +: CW]};
    end

endmodule

// File: rtl/da_inner_product.sv
// da_inner_product: bit-serial DA engine, y = sum c_k*x_k over K channels in W cycles, MSB first.
// DA_SIGNED_EN: two's-complement samples/coefficients, MSB cycle subtracts.
module da_inner_product
    import da_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int K  = 4,
    parameter  int CW = 8,
    localparam int OW = res_w(W, CW, K)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coef_we,
    input  logic [$clog2(K)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*W-1:0]       x_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        y_out,
    output logic                 busy
);

    localparam int LW  = lut_w(CW, K);
    localparam int CNW = $clog2(W);
`ifdef DA_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [CNW-1:0]  cnt_q, cnt_d;
    logic [K*W-1:0]  x_q, x_d;
    logic [OW-1:0]   acc_q, acc_d, y_q, y_d;
    logic [K*CW-1:0] coef_q, coef_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [K-1:0]    mask;
    logic [LW-1:0]   lut;
    logic [OW-1:0]   lut_ext, sum;

    always_comb begin
        mask = '0;
        for (int k = 0; k < K; k++)
            mask[k] = x_q[k*W + int'(cnt_q)];
    end

    da_lut #(.K(K), .CW(CW)) u_lut (.coef(coef_q), .mask(mask), .lut(lut));

    always_comb begin
        lut_ext = {{(OW-LW){SGN & lut[LW-1]}}, lut};
        // In signed mode the MSB carries negative weight, so its cycle starts the sum by subtracting.
        sum = (SGN && cnt_q == CNW'(W-1)) ? '0 - lut_ext : (acc_q << 1) + lut_ext;
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        acc_d   = acc_q;
        y_d     = y_q;
        coef_d  = coef_q;
        if (coef_we && state_q != RUN && int'(coef_addr) < K)
            coef_d[int'(coef_addr)*CW +: CW] = coef_data;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                x_d     = x_in;
                cnt_d   = CNW'(W-1);
                acc_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q - CNW'(1);
                if (cnt_q == '0) begin
                    y_d     = sum;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
        busy_d      = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            coef_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            coef_q      <= coef_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y_out     = y_q;

endmodule

// File: tb/tb_da_inner_product.sv
// tb_da_inner_product: directed-vector bench for da_inner_product (W=8, K=4, CW=8).
// Expected values follow DA_SIGNED_EN when the bench is built with it.
module tb_da_inner_product;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] y_out;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    da_inner_product #(.W(8), .K(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .out_valid(out_valid),
        .out_ready(out_ready), .y_out(y_out), .busy(busy)
    );

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_coefs(input logic [7:0] c0, c1, c2, c3);
        write_coef(2'd0, c0); write_coef(2'd1, c1); write_coef(2'd2, c2); write_coef(2'd3, c3);
    endtask

    // Sends one vector, scrambles x_in after acceptance, optionally writes coef[0]=9 at cycle wr_at.
    task automatic run_vec(input logic [31:0] x, input int wr_at, output int lat, output logic [17:0] y);
        @(negedge clk);
        in_valid = 1'b1; x_in = x;
        @(negedge clk);
        in_valid = 1'b0; x_in = 32'hA5C3_5A3C;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            coef_we = (i == wr_at); coef_addr = 2'd0; coef_data = 8'd9;
        end
        coef_we = 1'b0;
        y = y_out;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp += 4;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (y_out !== 18'd0) begin n_fail++; $display("FAIL rst_y: got %0d want 0", y_out); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        int lat;
        logic [17:0] y;
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        run_vec(32'h0101_0101, -1, lat, y);
        n_cmp += 3;
        if (y !== 18'd10) begin n_fail++; $display("FAIL basic_y: got %0d want 10", y); end
        if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_in_ready: got %b want 0", in_ready); end
        consume();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_consume_ready: got %b want 1", in_ready); end
        run_vec({8'd40, 8'd30, 8'd20, 8'd10}, -1, lat, y);
        n_cmp++;
        if (y !== 18'd300) begin n_fail++; $display("FAIL basic_mixed_y: got %0d want 300", y); end
        consume();
    endtask

    task automatic test_max;
        int lat;
        logic [17:0] y, exp_y;
`ifdef DA_SIGNED_EN
        exp_y = 18'd4;
`else
        exp_y = 18'd260100;
`endif
        load_coefs(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_vec(32'hFFFF_FFFF, -1, lat, y);
        n_cmp++;
        if (y !== exp_y) begin n_fail++; $display("FAIL max_y: got %0d want %0d", y, exp_y); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [17:0] y;
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        run_vec({8'd0, 8'd0, 8'd0, 8'd5}, -1, lat, y);
        n_cmp++;
        if (y !== 18'd5) begin n_fail++; $display("FAIL bp_y: got %0d want 5", y); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (y_out !== y) begin n_fail++; $display("FAIL bp_hold_y[%0d]: got %0d want %0d", i, y_out, y); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
        end
        consume();
        n_cmp += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_coef_write_busy;
        int lat;
        logic [17:0] y;
        run_vec(32'h0101_0101, 2, lat, y);
        n_cmp++;
        if (y !== 18'd10) begin n_fail++; $display("FAIL busy_write_cur: got %0d want 10", y); end
        consume();
        run_vec(32'h0101_0101, -1, lat, y);
        n_cmp++;
        if (y !== 18'd10) begin n_fail++; $display("FAIL busy_write_next: got %0d want 10", y); end
        consume();
        write_coef(2'd0, 8'd9);
        run_vec(32'h0101_0101, -1, lat, y);
        n_cmp++;
        if (y !== 18'd18) begin n_fail++; $display("FAIL idle_write: got %0d want 18", y); end
        consume();
    endtask

    task automatic test_signed_patterns;
        int lat;
        logic [17:0] y, exp_a;
`ifdef DA_SIGNED_EN
        exp_a = 18'd128;
`else
        exp_a = 18'd32640;
`endif
        load_coefs(8'hFF, 8'h00, 8'h00, 8'h00);
        run_vec(32'h0000_0080, -1, lat, y);
        n_cmp++;
        if (y !== exp_a) begin n_fail++; $display("FAIL sgn_single: got %0d want %0d", y, exp_a); end
        consume();
        load_coefs(8'h80, 8'h80, 8'h80, 8'h80);
        run_vec(32'h8080_8080, -1, lat, y);
        n_cmp++;
        if (y !== 18'd65536) begin n_fail++; $display("FAIL sgn_all80: got %0d want 65536", y); end
        consume();
    endtask

    task automatic test_reset_mid_run;
        int lat, seen;
        logic [17:0] y;
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4);
        @(negedge clk);
        in_valid = 1'b1; x_in = 32'h0101_0101;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (y_out !== 18'd0) begin n_fail++; $display("FAIL mid_rst_y: got %0d want 0", y_out); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_fail++; $display("FAIL mid_no_valid: got %0d valid cycles want 0", seen); end
        run_vec(32'h0101_0101, -1, lat, y);
        n_cmp += 2;
        if (y !== 18'd0) begin n_fail++; $display("FAIL mid_coef_cleared: got %0d want 0", y); end
        if (lat !== 8) begin n_fail++; $display("FAIL mid_after_latency: got %0d want 8", lat); end
        consume();
        write_coef(2'd0, 8'd5);
        run_vec(32'h0000_0003, -1, lat, y);
        n_cmp++;
        if (y !== 18'd15) begin n_fail++; $display("FAIL mid_after_y: got %0d want 15", y); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_coef_write_busy();
        test_signed_patterns();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
